tristate_bus_arbiter: RTL and testbench

- Shares one tristate bus between N_REQ tristate-buffer drivers. Each driver has its own enable.
- Grants bus ownership round-robin and enforces a maximum hold time.
- Inserts a turnaround gap with all enables low, so two drivers never drive the bus in the same cycle.
- Sits between requesting agents and the per-agent tristate buffers; drive_en[i] connects directly to buffer i's enable.

---
 rtl/tristate_bus_pkg.sv | 19 +
 rtl/tristate_bus_arbiter_rr_pick.sv | 31 +++
 rtl/tristate_bus_arbiter.sv | 137 +++++++++++++
 tb/tb_tristate_bus_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tristate_bus_pkg.sv
// Shared types and sizing helpers for the tristate bus arbiter.
package tristate_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_e;

    // Hold counter covers MAX_HOLD up to 255; turnaround counter up to 7.
    localparam int HOLD_W = 8;
    localparam int TURN_W = 3;

    // Index width for an N-entry one-hot vector (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tristate_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping at N. Kept generic so other arbiters can reuse it.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] index_o,
    output logic          valid_o
);

    // Scan N positions starting at the pointer; the first hit wins.
    always_comb begin
        onehot_o = '0;
        index_o  = '0;
        valid_o  = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(ptr_i) + k;
            if (j >= N) j = j - N;
            if (!valid_o && req_i[j]) begin
                valid_o     = 1'b1;
                onehot_o[j] = 1'b1;
                index_o     = IW'(j);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tristate bus. Each grant is bounded by
// MAX_HOLD cycles and followed by TURNAROUND all-enables-low cycles plus one
// IDLE arbitration cycle, so no two buffers ever drive together.
module tristate_bus_arbiter
    import tristate_bus_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int MAX_HOLD   = 16,
    parameter int TURNAROUND = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          drive_en,
    output logic [idx_w(N_REQ)-1:0]   owner_id,
    output logic                      bus_busy,
    output logic                      preempt
);

    localparam int IW = idx_w(N_REQ);

    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
        $error("tristate_bus_arbiter: N_REQ must be 2..16");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("tristate_bus_arbiter: MAX_HOLD must be 1..255");
    end
    if (TURNAROUND < 1 || TURNAROUND > 7) begin : g_bad_turn
        $error("tristate_bus_arbiter: TURNAROUND must be 1..7");
    end

    state_e             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [TURN_W-1:0]  turn_q, turn_d;
    logic               busy_q, busy_d;
    logic               preempt_q, preempt_d;

    logic [N_REQ-1:0]   pick_onehot;
    logic [IW-1:0]      pick_index;
    logic               pick_valid;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .index_o  (pick_index),
        .valid_o  (pick_valid)
    );

    // State and output registers; reset drops every enable immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            grant_q   <= '0;
            hold_q    <= '0;
            turn_q    <= '0;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            hold_q    <= hold_d;
            turn_q    <= turn_d;
            busy_q    <= busy_d;
            preempt_q <= preempt_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, count hold in DRIVE, gap in TURN.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        hold_d    = hold_q;
        turn_d    = turn_q;
        busy_d    = busy_q;
        preempt_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = DRIVE;
                    grant_d = pick_onehot;
                    owner_d = pick_index;
                    hold_d  = HOLD_W'(1);
                    busy_d  = 1'b1;
                end
            end
            DRIVE: begin
                if (!req[owner_q] || hold_q == HOLD_W'(MAX_HOLD)) begin
                    state_d   = TURN;
                    grant_d   = '0;
                    owner_d   = '0;
                    hold_d    = '0;
                    ptr_d     = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                    turn_d    = TURN_W'(TURNAROUND);
                    busy_d    = 1'b1;
                    // Only a forced exit counts; a voluntary release is silent.
                    preempt_d = req[owner_q];
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            TURN: begin
                if (turn_q <= TURN_W'(1)) begin
                    state_d = IDLE;
                    turn_d  = '0;
                    busy_d  = 1'b0;
                end else begin
                    turn_d = turn_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                owner_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Enables mirror the grant: the grant register is only nonzero in DRIVE.
    assign grant    = grant_q;
    assign drive_en = grant_q;
    assign owner_id = owner_q;
    assign bus_busy = busy_q;
    assign preempt  = preempt_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Directed checks on a MAX_HOLD=4/TURNAROUND=1 instance plus a random
// invariant soak on a MAX_HOLD=4/TURNAROUND=2 instance sharing the inputs.
module tb_tristate_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;

    logic [3:0] grant,  drive_en;
    logic [1:0] owner_id;
    logic       bus_busy, preempt;
    logic [3:0] grant2, drive_en2;
    logic [1:0] owner_id2;
    logic       bus_busy2, preempt2;

    int ntests = 0;
    int nfail  = 0;

    tristate_bus_arbiter #(.N_REQ(4), .MAX_HOLD(4), .TURNAROUND(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(grant), .drive_en(drive_en), .owner_id(owner_id),
        .bus_busy(bus_busy), .preempt(preempt)
    );

    tristate_bus_arbiter #(.N_REQ(4), .MAX_HOLD(4), .TURNAROUND(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req),
        .grant(grant2), .drive_en(drive_en2), .owner_id(owner_id2),
        .bus_busy(bus_busy2), .preempt(preempt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic chk_drive(input string tag, input int o);
        check({tag, "_de"},    32'(drive_en), 32'(1 << o));
        check({tag, "_owner"}, 32'(owner_id), 32'(o));
        check({tag, "_busy"},  32'(bus_busy), 32'd1);
    endtask

    // Invariant monitor for the TURNAROUND=2 instance during the soak.
    logic       mon_en = 1'b0;
    logic [3:0] prev_de;
    int         run_len, zeros, grants;
    logic       seen;

    always @(negedge clk) begin
        if (!mon_en) begin
            prev_de = '0; run_len = 0; zeros = 0; seen = 1'b0; grants = 0;
        end else begin
            check("inv_onehot0", 32'($onehot0(drive_en2)), 32'd1);
            if (drive_en2 != 4'b0) begin
                check("inv_de_eq_grant", 32'(drive_en2), 32'(grant2));
                check("inv_busy_in_drive", 32'(bus_busy2), 32'd1);
                if (prev_de == 4'b0) begin
                    grants++;
                    if (seen) check("inv_gap_ge3", 32'(zeros >= 3), 32'd1);
                    run_len = 1;
                end else begin
                    run_len++;
                end
                check("inv_hold_le_max", 32'(run_len <= 4), 32'd1);
                seen  = 1'b1;
                zeros = 0;
            end else begin
                zeros++;
            end
            prev_de = drive_en2;
        end
    end

    initial begin
        int seq [5] = '{0, 1, 2, 3, 0};
        rst_n = 1'b1;
        req   = 4'b0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_grant",    32'(grant),    32'd0);
        check("rst_de",       32'(drive_en), 32'd0);
        check("rst_owner",    32'(owner_id), 32'd0);
        check("rst_busy",     32'(bus_busy), 32'd0);
        check("rst_preempt",  32'(preempt),  32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single requester, voluntary release after 3 cycles
        req = 4'b0010;
        tick(); chk_drive("t1_c1", 1);
        tick(); chk_drive("t1_c2", 1);
        tick(); chk_drive("t1_c3", 1);
        req = 4'b0000;
        tick();
        check("t1_turn_de",   32'(drive_en), 32'd0);
        check("t1_turn_busy", 32'(bus_busy), 32'd1);
        check("t1_turn_pre",  32'(preempt),  32'd0);
        tick();
        check("t1_idle_busy", 32'(bus_busy), 32'd0);
        check("t1_idle_de",   32'(drive_en), 32'd0);

        // 2: all requesting, round-robin with preemption every 4 cycles
        do_reset();
        req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 4; c++) begin
                chk_drive($sformatf("t2_o%0d_c%0d", k, c), seq[k]);
                check($sformatf("t2_o%0d_c%0d_pre", k, c), 32'(preempt), 32'd0);
                tick();
            end
            check($sformatf("t2_o%0d_turn_de", k),  32'(drive_en), 32'd0);
            check($sformatf("t2_o%0d_turn_pre", k), 32'(preempt),  32'd1);
            check($sformatf("t2_o%0d_turn_bsy", k), 32'(bus_busy), 32'd1);
            tick();
            check($sformatf("t2_o%0d_idle_de", k),  32'(drive_en), 32'd0);
            check($sformatf("t2_o%0d_idle_pre", k), 32'(preempt),  32'd0);
            check($sformatf("t2_o%0d_idle_bsy", k), 32'(bus_busy), 32'd0);
            if (k == 4) req = 4'b0000;
            tick();
        end
        check("t2_end_de", 32'(drive_en), 32'd0);

        // 3: agents 0 and 3; agent 3 waits for agent 0's full hold
        do_reset();
        req = 4'b1001;
        tick();
        for (int c = 0; c < 4; c++) begin
            chk_drive($sformatf("t3_a0_c%0d", c), 0);
            tick();
        end
        check("t3_turn_pre", 32'(preempt),  32'd1);
        check("t3_turn_de",  32'(drive_en), 32'd0);
        tick();
        check("t3_idle_de",  32'(drive_en), 32'd0);
        tick();
        chk_drive("t3_a3", 3);
        req = 4'b0000;
        tick();
        check("t3_rel_pre",  32'(preempt),  32'd0);
        check("t3_rel_de",   32'(drive_en), 32'd0);
        tick();

        // 4: async reset mid-DRIVE, then fresh grant with full hold
        do_reset();
        req = 4'b0100;
        tick(); chk_drive("t4_pre_c1", 2);
        tick(); chk_drive("t4_pre_c2", 2);
        #3 rst_n = 1'b0;
        #1;
        check("t4_async_de",    32'(drive_en), 32'd0);
        check("t4_async_grant", 32'(grant),    32'd0);
        check("t4_async_busy",  32'(bus_busy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            chk_drive($sformatf("t4_post_c%0d", c), 2);
            tick();
        end
        check("t4_post_pre", 32'(preempt),  32'd1);
        check("t4_post_de",  32'(drive_en), 32'd0);
        req = 4'b0000;
        tick(2);

        // 6: one-cycle req[1] pulse during agent 0's TURN is never granted
        do_reset();
        req = 4'b0001;
        tick(); chk_drive("t6_a0", 0);
        req = 4'b0000;
        tick();
        check("t6_turn_de", 32'(drive_en), 32'd0);
        req = 4'b0010;
        tick();
        check("t6_idle_grant", 32'(grant), 32'd0);
        req = 4'b0000;
        tick();
        check("t6_after1_grant", 32'(grant), 32'd0);
        tick();
        check("t6_after2_grant", 32'(grant), 32'd0);
        check("t6_after2_busy",  32'(bus_busy), 32'd0);

        // 5: random soak on the TURNAROUND=2 instance
        do_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            tick();
        end
        check("t5_grants_seen", 32'(grants > 100), 32'd1);
        mon_en = 1'b0;
        req = 4'b0000;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
